// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
// Holds the arbiter state encoding, bus widths and the fetch byte-enable pattern.
package bus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] FETCH_SEL = 4'b1111;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_BUSY_IF  = 2'd1,
    ARB_BUSY_MEM = 2'd2,
    ARB_DRAIN    = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Instruction fetches are always full-word reads.
  function automatic bus_req_t fetch_req(input logic [ADDR_W-1:0] pc);
    bus_req_t r;
    r.we    = 1'b0;
    r.sel   = FETCH_SEL;
    r.addr  = pc;
    r.wdata = '0;
    return r;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// External single-port memory bus: cyc/ack transaction with registered master outputs.
// The arbiter is the master; the memory slave sees the complementary view.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic              cyc;
  logic              we;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;

  modport master (
    output cyc, we, sel, addr, wdata, err,
    input  rdata, ack
  );

  modport slave (
    input  cyc, we, sel, addr, wdata, err,
    output rdata, ack
  );

endinterface

// File: rtl/bus_arbiter_port_buf.sv
// Result holding buffer for one pipeline port: captures bus data and keeps it
// valid until the owning stage advances or the result is flushed.
module arb_port_buf
  import bus_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              consume_i,
  input  logic              flush_i,
  output logic              rdy_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic              rdy_q, rdy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // A new capture never coincides with a consume: the port is not re-issued while rdy is set.
  always_comb begin
    rdy_d   = rdy_q;
    rdata_d = rdata_q;
    if (set_i) begin
      rdy_d   = 1'b1;
      rdata_d = data_i;
    end else if (flush_i || (rdy_q && consume_i)) begin
      rdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdy_o   = rdy_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_arbiter.sv
// Shares one variable-latency memory bus between instruction fetch and the data port.
// Data port has fixed priority, no preemption, and hung accesses are aborted after MAX_WAIT cycles.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_rdy_o,
  output logic              stallreq_if_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [SEL_W-1:0]  mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_rdy_o,
  output logic              stallreq_mem_o,
  bus_arbiter_if.master     bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  bus_req_t          req_q, req_d;
  logic              err_q, err_d;

  logic              if_set, mem_set;
  logic [DATA_W-1:0] cap_data;
  logic              timeout;
  logic              unused_stall;

  assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

  assign timeout = !bus.ack && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    req_d    = req_q;
    err_d    = 1'b0;
    if_set   = 1'b0;
    mem_set  = 1'b0;
    cap_data = bus.ack ? bus.rdata : '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (mem_req_i && !mem_rdy_o) begin
          state_d     = ARB_BUSY_MEM;
          cyc_d       = 1'b1;
          cnt_d       = '0;
          req_d.we    = mem_we_i;
          req_d.sel   = mem_sel_i;
          req_d.addr  = mem_addr_i;
          req_d.wdata = mem_wdata_i;
        end else if (if_req_i && !if_rdy_o) begin
          state_d = ARB_BUSY_IF;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          req_d   = fetch_req(if_addr_i);
        end
      end

      ARB_BUSY_IF: begin
        if (flush_i) begin
          // Flush beats a same-edge ack; an access still pending is drained with its result dropped.
          if (bus.ack || timeout) begin
            state_d = ARB_IDLE;
            cyc_d   = 1'b0;
            err_d   = timeout;
          end else begin
            state_d = ARB_DRAIN;
            cnt_d   = '0;
          end
        end else if (bus.ack || timeout) begin
          state_d = ARB_IDLE;
          cyc_d   = 1'b0;
          err_d   = timeout;
          if_set  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ARB_BUSY_MEM: begin
        if (bus.ack || timeout) begin
          state_d = ARB_IDLE;
          cyc_d   = 1'b0;
          err_d   = timeout;
          mem_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ARB_DRAIN: begin
        if (bus.ack || timeout) begin
          state_d = ARB_IDLE;
          cyc_d   = 1'b0;
          err_d   = timeout;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ARB_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  assign bus.cyc   = cyc_q;
  assign bus.we    = req_q.we;
  assign bus.sel   = req_q.sel;
  assign bus.addr  = req_q.addr;
  assign bus.wdata = req_q.wdata;
  assign bus.err   = err_q;

  arb_port_buf u_if_buf (
    .clk       (clk),
    .rst       (rst),
    .set_i     (if_set),
    .data_i    (cap_data),
    .consume_i (!stall_i[1]),
    .flush_i   (flush_i),
    .rdy_o     (if_rdy_o),
    .rdata_o   (if_rdata_o)
  );

  arb_port_buf u_mem_buf (
    .clk       (clk),
    .rst       (rst),
    .set_i     (mem_set),
    .data_i    (cap_data),
    .consume_i (!stall_i[4]),
    .flush_i   (1'b0),
    .rdy_o     (mem_rdy_o),
    .rdata_o   (mem_rdata_o)
  );

  assign stallreq_if_o  = if_req_i && !if_rdy_o;
  assign stallreq_mem_o = mem_req_i && !mem_rdy_o;

endmodule
